axis_pattern_filter: RTL and testbench

AXIS_PATTERN_FILTER -- requirements
Module: axis_pattern_filter

---
 rtl/axis_pattern_filter_pkg.sv | 9 +
 rtl/axis_reg_slice.sv | 29 ++
 rtl/axis_pattern_filter.sv | 144 ++++++++++++++
 tb/tb_axis_pattern_filter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_filter_pkg.sv
// Shared types for the AXI-stream keep/drop pattern filter.
package axis_pattern_filter_pkg;

    typedef enum logic {
        S_KEEP = 1'b0,
        S_DROP = 1'b1
    } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-stream output register: one-cycle latency, full throughput.
module axis_reg_slice #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data
);

    assign src_ready = !dst_valid || dst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid <= 1'b0;
            dst_data  <= '0;
        end else if (src_ready) begin
            dst_valid <= src_valid;
            if (src_valid) begin
                dst_data <= src_data;
            end
        end
    end

endmodule

// File: rtl/axis_pattern_filter.sv
// Forwards KEEP accepted beats, then discards DROP accepted beats, repeating.
// Define AXIS_PATTERN_FILTER_LAST_EN to add output_last (final beat of each keep run).
module axis_pattern_filter
    import axis_pattern_filter_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int COUNT_WIDTH        = 8,
    parameter int DEFAULT_KEEP       = 255,
    parameter int DEFAULT_DROP       = 1,
    parameter int DEFAULT_START_KEEP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] cfg_keep,
    input  logic [COUNT_WIDTH-1:0] cfg_drop,
    input  logic                   cfg_start_keep,
    input  logic                   cfg_load,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH-1:0]  input_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [DATA_WIDTH-1:0]  output_data
`ifdef AXIS_PATTERN_FILTER_LAST_EN
    ,
    output logic                   output_last
`endif
);

`ifdef AXIS_PATTERN_FILTER_LAST_EN
    localparam int SLICE_W = DATA_WIDTH + 1;
`else
    localparam int SLICE_W = DATA_WIDTH;
`endif

    localparam state_t RST_STATE =
        (DEFAULT_START_KEEP != 0) ? S_KEEP : S_DROP;

    state_t                 state;
    state_t                 state_nx;
    state_t                 eff_state;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_nx;
    logic [COUNT_WIDTH-1:0] keep_r;
    logic [COUNT_WIDTH-1:0] keep_nx;
    logic [COUNT_WIDTH-1:0] drop_r;
    logic [COUNT_WIDTH-1:0] drop_nx;
    logic [COUNT_WIDTH:0]   count_inc;
    logic                   passthru;
    logic                   keeping;
    logic                   keep_end;
    logic                   drop_end;
    logic                   accept;
    logic                   slice_ready;
    logic [SLICE_W-1:0]     slice_in;
    logic [SLICE_W-1:0]     slice_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RST_STATE;
            count  <= '0;
            keep_r <= COUNT_WIDTH'(DEFAULT_KEEP);
            drop_r <= COUNT_WIDTH'(DEFAULT_DROP);
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            keep_r <= keep_nx;
            drop_r <= drop_nx;
        end
    end

    // A zero-length run is skipped, so the effective state may differ
    // from the stored one; widened compare avoids wrap at all-ones.
    always_comb begin
        passthru  = (keep_r == '0) && (drop_r == '0);
        eff_state = state;
        if (passthru) begin
            eff_state = S_KEEP;
        end else if (state == S_KEEP && keep_r == '0) begin
            eff_state = S_DROP;
        end else if (state == S_DROP && drop_r == '0) begin
            eff_state = S_KEEP;
        end
        keeping   = (eff_state == S_KEEP);
        count_inc = {1'b0, count} + (COUNT_WIDTH + 1)'(1);
        keep_end  = (count_inc == {1'b0, keep_r});
        drop_end  = (count_inc == {1'b0, drop_r});
    end

    assign input_ready = !rst && (keeping ? slice_ready : 1'b1);
    assign accept      = input_valid && input_ready;

    always_comb begin
        state_nx = state;
        count_nx = count;
        keep_nx  = keep_r;
        drop_nx  = drop_r;
        if (cfg_load) begin
            keep_nx  = cfg_keep;
            drop_nx  = cfg_drop;
            count_nx = '0;
            state_nx = cfg_start_keep ? S_KEEP : S_DROP;
        end else if (accept && !passthru) begin
            if (keeping) begin
                if (keep_end) begin
                    count_nx = '0;
                    state_nx = (drop_r != '0) ? S_DROP : S_KEEP;
                end else begin
                    count_nx = count_inc[COUNT_WIDTH-1:0];
                end
            end else begin
                if (drop_end) begin
                    count_nx = '0;
                    state_nx = (keep_r != '0) ? S_KEEP : S_DROP;
                end else begin
                    count_nx = count_inc[COUNT_WIDTH-1:0];
                end
            end
        end
    end

`ifdef AXIS_PATTERN_FILTER_LAST_EN
    assign slice_in    = {keeping && !passthru && keep_end, input_data};
    assign output_last = slice_out[DATA_WIDTH];
    assign output_data = slice_out[DATA_WIDTH-1:0];
`else
    assign slice_in    = input_data;
    assign output_data = slice_out;
`endif

    axis_reg_slice #(
        .WIDTH(SLICE_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .src_valid(accept && keeping),
        .src_ready(slice_ready),
        .src_data (slice_in),
        .dst_valid(output_valid),
        .dst_ready(output_ready),
        .dst_data (slice_out)
    );

endmodule

// File: tb/tb_axis_pattern_filter.sv
// Directed scoreboard bench for axis_pattern_filter.
// Build with AXIS_PATTERN_FILTER_LAST_EN to also check output_last.
module tb_axis_pattern_filter;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [7:0]  cfg_keep;
    logic [7:0]  cfg_drop;
    logic        cfg_start_keep;
    logic        cfg_load;
    logic        input_valid;
    logic        input_ready;
    logic [15:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [15:0] output_data;
`ifdef AXIS_PATTERN_FILTER_LAST_EN
    logic        output_last;
`endif

    int    errors;
    int    checks;
    beat_t exp_q[$];
    int    mk;
    int    md;
    bit    mstart;
    int    mn;
    bit    or_rand;
    bit    or_val;
    bit    hold_prev;
    logic [15:0] prev_data;

    axis_pattern_filter dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_keep      (cfg_keep),
        .cfg_drop      (cfg_drop),
        .cfg_start_keep(cfg_start_keep),
        .cfg_load      (cfg_load),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .input_data    (input_data),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .output_data   (output_data)
`ifdef AXIS_PATTERN_FILTER_LAST_EN
        ,
        .output_last   (output_last)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_kept(input int n);
        int p;
        if (mk == 0 && md == 0) return 1'b1;
        p = n % (mk + md);
        return mstart ? (p < mk) : (p >= md);
    endfunction

    function automatic bit m_last(input int n);
        int p;
        if (mk == 0 && md == 0) return 1'b0;
        p = n % (mk + md);
        return mstart ? (p == mk - 1) : (p == mk + md - 1);
    endfunction

    always @(posedge clk) begin
        #1;
        output_ready = or_rand ? 1'($urandom_range(0, 1)) : or_val;
    end

    // Transfers happen at the next posedge; nothing changes before it.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(output_valid), 32'd1);
                check("hold_data", 32'(output_data), 32'(prev_data));
            end
            if (output_valid && output_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(output_data), 32'(e.d));
`ifdef AXIS_PATTERN_FILTER_LAST_EN
                    check("out_last", 32'(output_last), 32'(e.l));
`endif
                end
            end
            hold_prev = output_valid && !output_ready;
            prev_data = output_data;
        end
    end

    task automatic send(input logic [15:0] d);
        bit k;
        bit l;
        bit done;
        k = m_kept(mn);
        l = m_last(mn);
        input_valid = 1'b1;
        input_data  = d;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (i == 0 && !k) check("drop_ready", 32'(input_ready), 32'd1);
            if (input_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        check("accept_timeout", 32'(done), 32'd1);
        if (done) begin
            mn++;
            if (k) exp_q.push_back('{d: d, l: l});
        end
    endtask

    task automatic load(input int k, input int d, input bit s);
        cfg_keep       = 8'(k);
        cfg_drop       = 8'(d);
        cfg_start_keep = s;
        cfg_load       = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        mk = k;
        md = d;
        mstart = s;
        mn = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        or_rand = 1'b0;
        or_val = 1'b1;
        output_ready = 1'b1;
        hold_prev = 1'b0;
        prev_data = '0;
        rst = 1'b1;
        cfg_keep = 8'd0;
        cfg_drop = 8'd0;
        cfg_start_keep = 1'b0;
        cfg_load = 1'b0;
        input_valid = 1'b0;
        input_data = '0;
        mk = 255;
        md = 1;
        mstart = 1'b1;
        mn = 0;

        @(negedge clk);
        check("rst_ready", 32'(input_ready), 32'd0);
        check("rst_valid", 32'(output_valid), 32'd0);
        check("rst_data", 32'(output_data), 32'd0);
`ifdef AXIS_PATTERN_FILTER_LAST_EN
        check("rst_last", 32'(output_last), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // defaults: 255 kept, 1 dropped
        for (int i = 0; i < 512; i++) send(16'(i));
        drain();

        load(2, 3, 1'b0);
        for (int i = 0; i < 10; i++) send(16'(i));
        drain();

        or_rand = 1'b1;
        load(4, 2, 1'b1);
        for (int i = 0; i < 48; i++) send(16'(16'h1000 + i));
        drain();

        load(0, 0, 1'b1);
        for (int i = 0; i < 20; i++) send(16'(16'h2000 + i));
        drain();
        or_rand = 1'b0;

        // reconfigure while a beat is held in the output register
        load(3, 1, 1'b1);
        or_val = 1'b0;
        wait_cycles(2);
        send(16'h0100);
        @(negedge clk);
        check("held_valid", 32'(output_valid), 32'd1);
        check("held_data", 32'(output_data), 32'h0100);
        @(posedge clk);
        #1;
        load(1, 1, 1'b1);
        or_val = 1'b1;
        for (int i = 0; i < 6; i++) send(16'(16'h0200 + i));
        drain();

        // reset with a held beat and a competing cfg_load
        or_val = 1'b0;
        wait_cycles(2);
        send(16'h0300);
        @(negedge clk);
        check("pre_rst_valid", 32'(output_valid), 32'd1);
        @(posedge clk);
        #1;
        cfg_keep = 8'd2;
        cfg_drop = 8'd2;
        cfg_start_keep = 1'b0;
        cfg_load = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(input_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_load = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_valid", 32'(output_valid), 32'd0);
        check("post_rst_data", 32'(output_data), 32'd0);
        @(posedge clk);
        #1;
        mk = 255;
        md = 1;
        mstart = 1'b1;
        mn = 0;
        or_val = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < 260; i++) send(16'(16'h4000 + i));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
